// File: rtl/msk_key_ctrl_pkg.sv
// msk_key_ctrl_pkg: shared state encoding, refresh latency and word-type codes
package msk_key_ctrl_pkg;
  localparam logic [2:0] ST_SEED = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_KEY = 3'd2;
  localparam logic [2:0] ST_READY = 3'd3;
  localparam logic [2:0] ST_RFSH = 3'd4;
  localparam logic [2:0] ST_ERR = 3'd5;
  typedef enum logic [2:0] {
    SEED = ST_SEED,
    FILL = ST_FILL,
    KEY = ST_KEY,
    READY = ST_READY,
    RFSH = ST_RFSH,
    ERR = ST_ERR
  } state_t;
  localparam int RFSH_LAT = 2;
  localparam logic TYPE_SEED = 1'b1;
  localparam logic TYPE_KEY = 1'b0;
endpackage

// File: rtl/msk_rfrsh_timer.sv
// msk_rfrsh_timer: periodic auto-refresh counter with a sticky pending flag
module msk_rfrsh_timer #(
  parameter int PERIOD = 8
) (
  input  logic clk,
  input  logic pre_rst,
  input  logic en,
  input  logic clr,
  output logic pending
);
  localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  logic [CW-1:0] cnt;
  // counting stops once pending; the issued refresh restarts the period
  always_ff @(posedge clk)
    if (pre_rst || clr) begin
      cnt <= '0;
      pending <= 1'b0;
    end else if (en && !pending) begin
      if (cnt == CW'(PERIOD - 1)) pending <= 1'b1;
      else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/msk_key_rfrsh_ctrl.sv
// msk_key_rfrsh_ctrl: sequences seeding, key loading and share refreshes
module msk_key_rfrsh_ctrl
  import msk_key_ctrl_pkg::*;
#(
  parameter int SIZE_FEED = 32,
  parameter int SEED_WORDS = 4,
  parameter int KEY_WORDS = 4,
  parameter int AUTO_RFSH_PERIOD = 0
) (
  input  logic                 clk,
  input  logic                 pre_rst,
  input  logic [SIZE_FEED-1:0] bus_data,
  input  logic                 bus_valid,
  input  logic                 bus_is_seed,
  output logic                 bus_ready,
  output logic [SIZE_FEED-1:0] holder_data,
  output logic                 holder_data_valid,
  output logic                 feed_prng_seed,
  output logic                 n_lock_for_seed,
  input  logic                 rnd_ready,
  output logic                 pre_pre_refresh,
  input  logic                 rfrsh_req,
  output logic                 rfrsh_ack,
  output logic                 key_valid,
  output logic                 err
);
  localparam int MW = SEED_WORDS > KEY_WORDS ? SEED_WORDS : KEY_WORDS;
  localparam int WW = MW > 1 ? $clog2(MW) : 1;
  state_t st, st_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [1:0] rcnt, rcnt_n;
  logic src, src_n, pending, issue, seed_w, key_w;
  assign seed_w = bus_valid && bus_is_seed == TYPE_SEED;
  assign key_w = bus_valid && bus_is_seed == TYPE_KEY;
  always_ff @(posedge clk)
    if (pre_rst) begin
      st <= SEED;
      wcnt <= '0;
      rcnt <= '0;
      src <= 1'b0;
    end else begin
      st <= st_n;
      wcnt <= wcnt_n;
      rcnt <= rcnt_n;
      src <= src_n;
    end
  always_comb begin
    st_n = st;
    wcnt_n = wcnt;
    rcnt_n = rcnt;
    src_n = src;
    issue = 1'b0;
    rfrsh_ack = 1'b0;
    case (st)
      SEED:
        if (key_w) st_n = ERR;
        else if (seed_w) begin
          st_n = wcnt == WW'(SEED_WORDS - 1) ? FILL : SEED;
          wcnt_n = wcnt == WW'(SEED_WORDS - 1) ? '0 : wcnt + 1'b1;
        end
      FILL: st_n = rnd_ready ? KEY : FILL;
      KEY:
        if (seed_w) st_n = ERR;
        else if (key_w) begin
          st_n = wcnt == WW'(KEY_WORDS - 1) ? READY : KEY;
          wcnt_n = wcnt == WW'(KEY_WORDS - 1) ? '0 : wcnt + 1'b1;
        end
      READY:
        // an arriving word counts as word 0 of a fresh reseed/reload
        if (seed_w) begin
          st_n = SEED_WORDS == 1 ? FILL : SEED;
          wcnt_n = SEED_WORDS == 1 ? '0 : WW'(1);
        end else if (key_w) begin
          st_n = KEY_WORDS == 1 ? READY : KEY;
          wcnt_n = KEY_WORDS == 1 ? '0 : WW'(1);
        end else if ((rfrsh_req || pending) && rnd_ready) begin
          issue = 1'b1;
          src_n = rfrsh_req;
          rcnt_n = 2'(RFSH_LAT - 1);
          st_n = RFSH;
        end
      RFSH:
        if (rcnt == '0) begin
          st_n = READY;
          rfrsh_ack = src;
        end else rcnt_n = rcnt - 1'b1;
      default: st_n = ERR;
    endcase
  end
  generate
    if (AUTO_RFSH_PERIOD > 0) begin : g_tmr
      msk_rfrsh_timer #(.PERIOD(AUTO_RFSH_PERIOD)) u_tmr (
        .clk(clk),
        .pre_rst(pre_rst),
        .en(st == READY),
        .clr(issue),
        .pending(pending)
      );
    end else begin : g_tie
      assign pending = 1'b0;
    end
  endgenerate
  assign bus_ready = st == SEED || st == KEY || st == READY;
  assign holder_data = bus_data;
  assign holder_data_valid = bus_ready && (st == READY ? bus_valid : st == SEED ? seed_w : key_w);
  assign feed_prng_seed = st == SEED;
  assign n_lock_for_seed = st != SEED;
  assign pre_pre_refresh = issue;
  assign key_valid = st == READY;
  assign err = st == ERR;
endmodule

// File: doc/msk_key_rfrsh_ctrl.md
# msk_key_rfrsh_ctrl

Controller that sequences the masked key holder/refresher. It steers bus words into PRNG seeding or key loading, waits for PRNG readiness, and arbitrates share refreshes between the cipher core and an optional periodic timer. It sits between the input bus and the key holder/refresher block, driving its `feed_prng_seed`, `n_lock_for_seed` and `pre_pre_refresh` controls and observing `rnd_ready`.

## Interface
- `SIZE_FEED`, 32: bus word width.
- `SEED_WORDS`, 4: words per PRNG seed; must be ≥1.
- `KEY_WORDS`, 4: words per key (Nbits/SIZE_FEED); must be ≥1.
- `AUTO_RFSH_PERIOD`, 0: cycles in READY between automatic refreshes; 0 disables the timer.

Ports:
- `clk`  in  1  clock; all logic rises on this edge.
- `pre_rst`  in  1  reset; synchronous, active-high.
- `bus_data`  in  SIZE_FEED  word from the input bus.
- `bus_valid`  in  1  word present.
- `bus_is_seed`  in  1  word type: 1 = seed, 0 = key.
- `bus_ready`  out  1  controller accepts a word this cycle.
- `holder_data`  out  SIZE_FEED  equals `bus_data` (combinational).
- `holder_data_valid`  out  1  = bus_valid & bus_ready & type matches state.
- `feed_prng_seed`  out  1  high in SEED.
- `n_lock_for_seed`  out  1  low in SEED, high otherwise.
- `rnd_ready`  in  1  PRNG has fresh refresh randomness.
- `pre_pre_refresh`  out  1  single-cycle refresh command.
- `rfrsh_req`  in  1  core refresh request; level, held until ack.
- `rfrsh_ack`  out  1  one-cycle pulse when the refreshed sharing is valid.
- `key_valid`  out  1  sharing is loaded, refreshed and usable.
- `err`  out  1  sticky protocol error.

## Operation
- States: SEED, FILL, KEY, READY, RFSH, ERR.
- SEED:
  - `bus_ready`=1. Each accepted word with `bus_is_seed`=1 increments `wcnt`.
  - On word SEED_WORDS-1, clear `wcnt` and go to FILL.
  - A key-type word goes to ERR.
- FILL: `bus_ready`=0. Wait for `rnd_ready`=1, then go to KEY.
- KEY:
  - `bus_ready`=1. Key-type words increment `wcnt`.
  - On word KEY_WORDS-1, go to READY.
  - A seed-type word goes to ERR.
- READY:
  - `key_valid`=1 and `bus_ready`=1.
  - Priority: bus word > `rfrsh_req` > timer expiry.
  - A seed word is consumed as seed word 0 and moves to SEED (reseed).
  - A key word is consumed as key word 0 and moves to KEY.
  - A request with `rnd_ready`=1 raises `pre_pre_refresh` for that cycle and moves to RFSH. With `rnd_ready`=0 the request stays pending and the state stays READY.
- RFSH:
  - `bus_ready`=0, `key_valid`=0, 2-cycle countdown, then READY.
  - If the source was `rfrsh_req`, pulse `rfrsh_ack` on the last RFSH cycle.
- ERR: `bus_ready`=0 and `err`=1 until `pre_rst`.
- Timer:
  - Counts only in READY; holds its value in other states.
  - Reaching AUTO_RFSH_PERIOD-1 sets a pending auto request.
  - The counter and pending flag clear when a refresh is issued.
- `wcnt` width is clog2(max(SEED_WORDS, KEY_WORDS)), with a minimum of 1 bit.

## Timing
- Reset (`pre_rst` high at edge): state = SEED; `wcnt`, timer, pending flag and `err` = 0.
- Output values after reset:
  - `bus_ready`=1, `feed_prng_seed`=1, `n_lock_for_seed`=0.
  - `pre_pre_refresh`=0, `rfrsh_ack`=0, `key_valid`=0.
- `pre_rst` in any state, including mid-load or mid-RFSH, aborts the operation. No ack is issued for the aborted refresh.
- The data path has zero latency (`bus_data` → `holder_data`). State changes take effect on the cycle after the accepting edge.
- Refresh issued in cycle t:
  - `pre_pre_refresh`=1 in t.
  - `key_valid`=0 in t+1 and t+2.
  - `rfrsh_ack`=1 in t+2.
  - `key_valid`=1 in t+3.
- `rfrsh_req` still high in the cycle after its ack is treated as a new request.
- Simultaneous `rfrsh_req` and timer expiry produce one refresh, acked to the core. The auto pending flag clears.
- A reload that interrupts a pending `rfrsh_req` keeps it pending; it is served in READY after the reload.

## Structure
- Package `msk_key_ctrl_pkg` holds:
  - the state encoding (one localparam per state, 3 bits);
  - `RFSH_LAT`=2;
  - the word-type encodings `TYPE_SEED`=1 and `TYPE_KEY`=0.
- Sub-module `msk_rfrsh_timer`: the periodic counter plus pending flag. Inputs: `clk`, `pre_rst`, `en` (READY), `clr` (refresh issued). Output: `pending`. It is tied off when AUTO_RFSH_PERIOD=0.

## Test plan
- Reset, 4 seed words, hold `rnd_ready`=0 for 10 cycles, then 4 key words:
  - `feed_prng_seed`=1 on the seed words only;
  - `bus_ready`=0 during FILL;
  - `key_valid`=1 the cycle after key word 3.
- In READY, raise `rfrsh_req` at t with `rnd_ready`=1:
  - `pre_pre_refresh` at t, `rfrsh_ack` at t+2, `key_valid` back at t+3.
  - Repeat with `rnd_ready`=0 for 5 cycles: no pulse until `rnd_ready` rises.
- Send a key word while in SEED: `err`=1, `bus_ready`=0 permanently. Then `pre_rst`: `err`=0, state SEED.
- Set AUTO_RFSH_PERIOD=8 and idle in READY:
  - `pre_pre_refresh` every 11 cycles (8 counting + 3 refresh cycles);
  - no `rfrsh_ack`.
- In READY, assert a bus seed word and `rfrsh_req` in the same cycle: reseed proceeds, and the refresh plus ack occur only after the reload returns to READY.
- Assert `pre_rst` in the middle of KEY (word 2) and in RFSH: all outputs return to reset values, and no ack is issued.
